i2c_txn_arbiter: RTL and testbench
==================================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one i2c_controller between N_REQ requesters (APB register bank, sensor poller, etc.).
//  Round-robin grants one whole I2C transaction at a time, drives the controller's enable/address/data/repeated-start inputs,
//  and tracks controller busy with a timeout. Reports per-requester done or error.
//  Sits between the APB-side request sources and i2c_controller, in the i2c_core_clk domain.
// PARAMETERS
//  N_REQ       4     number of requesters (>=2)
//  TIMEOUT     4096  max i2c_core_clk cycles allowed in LAUNCH or WAIT_DONE before error
//  GAP_CYCLES  8     idle cycles enforced after each transaction (bus free time); >=1
// PORTS
//  i2c_core_clk        in   1        single clock; every register is on its rising edge
//  rst                 in   1        synchronous, active-high reset
//  req                 in   N_REQ    per-requester transaction request, level; held until done/err
//  req_addr            in   8*N_REQ  slave address+RW per requester; bits [8i+7:8i] = requester i
//  req_data            in   8*N_REQ  write data byte per requester
//  req_rsc             in   N_REQ    repeated-start request per requester
//  gnt                 out  N_REQ    one-hot grant; high from LAUNCH through RELEASE
//  done                out  N_REQ    1-cycle pulse: granted transaction completed
//  err                 out  N_REQ    1-cycle pulse: granted transaction timed out
//  busy                out  1        high in any state except IDLE
//  ctrl_enable         out  1        to controller enable
//  ctrl_slave_address  out  8        to controller slave_address (latched copy)
//  ctrl_data_in        out  8        to controller data_in (latched copy)
//  ctrl_repeated_start out  1        to controller repeated_start_cond (latched copy)
//  ctrl_busy           in   1        controller not in IDLE (synchronous to i2c_core_clk)
// BEHAVIOUR
//  Reset: state=IDLE; gnt=0, done=0, err=0, busy=0, ctrl_enable=0, ctrl_slave_address=0, ctrl_data_in=0,
//   ctrl_repeated_start=0, rr pointer=N_REQ-1 (so requester 0 wins first), timeout and gap counters=0.
//  Reset mid-transaction takes effect next edge; no done/err pulse is emitted for the aborted transaction.
//  All outputs registered. States: IDLE, LAUNCH, WAIT_DONE, RELEASE.
//  IDLE: if |req at edge k, pick first set bit searching ptr+1, ptr+2 ... wrapping modulo N_REQ.
//   At edge k: latch that requester's addr/data/rsc into ctrl_*, set gnt one-hot, ctrl_enable=1, -> LAUNCH.
//   So gnt/ctrl_enable are visible in cycle k+1 (1-cycle latency). req==0: stay, outputs unchanged.
//  LAUNCH: ctrl_enable held 1; ctrl_* stable. On ctrl_busy=1 -> WAIT_DONE, ctrl_enable<=0, counter cleared.
//   If counter reaches TIMEOUT-1 without ctrl_busy -> err[g] pulse, ctrl_enable<=0, -> RELEASE.
//  WAIT_DONE: ctrl_enable=0. On ctrl_busy=0 -> done[g] pulse, -> RELEASE.
//   Timeout as in LAUNCH -> err[g] pulse, -> RELEASE. done and err never both in one cycle.
//  RELEASE: gnt held; count GAP_CYCLES cycles; on last: gnt<=0, ptr<=granted index, -> IDLE.
//   A new grant can therefore issue no earlier than the edge after returning to IDLE.
//  Timeout counter: $clog2(TIMEOUT) bits, cleared on every state entry, saturating; never wraps.
//  ctrl_slave_address/data/rsc change only on the IDLE->LAUNCH edge; stable for whole transaction.
//  Requester dropping req after grant is ignored; transaction runs to done/err for that requester.
//  req changes on other lines during a transaction have no effect until IDLE.
//  Simultaneous requests: strictly round-robin; a requester holding req continuously is served
//   at least once every N_REQ transactions.
//  ctrl_busy already 1 in IDLE (controller stuck): no special case; LAUNCH exits to WAIT_DONE next edge.
// TESTING
//  1. Single req[0], addr 0xD7 data 0xAA; ctrl_busy high 2 cyc after enable, low 40 cyc later
//     -> gnt=0001 one cycle after req, ctrl_slave_address=0xD7, ctrl_data_in=0xAA, done[0] 1 pulse, no err.
//  2. req=1111 held, each transaction completes -> grant order 0,1,2,3,0; >=GAP_CYCLES idle between gnts.
//  3. req[2] with ctrl_busy tied 0 -> err[2] pulse exactly TIMEOUT cycles after LAUNCH entry;
//     ctrl_enable low after; gnt[2] clears after GAP_CYCLES; no done.
//  4. ctrl_busy stuck 1 after launch -> err pulse TIMEOUT cycles after WAIT_DONE entry; arbiter returns to IDLE.
//  5. rst pulsed during WAIT_DONE -> next cycle all outputs 0, no done/err; next req=0010 granted to 1.
//  6. req[1] dropped and req_addr[1] changed mid-transaction -> ctrl_* unchanged, done[1] still pulses.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter that shares one i2c_controller among N_REQ requesters.
// Each grant covers one whole I2C transaction. The arbiter launches the controller, follows
// ctrl_busy with a timeout, reports done/err to the granted requester, and then enforces a
// bus-free gap before it issues the next grant.
// Ports:
//   i2c_core_clk, rst         clock and synchronous active-high reset
//   req/req_addr/req_data/req_rsc   per-requester request level and transaction payload
//   gnt, done, err            one-hot grant, completion pulse, timeout pulse
//   busy                      arbiter is not idle
//   ctrl_enable, ctrl_slave_address, ctrl_data_in, ctrl_repeated_start   controller inputs
//   ctrl_busy                 controller is not idle
module i2c_txn_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                 i2c_core_clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_rsc,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err,
  output logic                 busy,
  output logic                 ctrl_enable,
  output logic [7:0]           ctrl_slave_address,
  output logic [7:0]           ctrl_data_in,
  output logic                 ctrl_repeated_start,
  input  logic                 ctrl_busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             ctrl_enable_q, ctrl_enable_d;
  logic [7:0]       ctrl_addr_q, ctrl_addr_d;
  logic [7:0]       ctrl_data_q, ctrl_data_d;
  logic             ctrl_rsc_q, ctrl_rsc_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [7:0]       lane_addr [N_REQ];
  logic [7:0]       lane_data [N_REQ];
  logic             found;
  logic [IW-1:0]    pick;

  // Split the flat payload buses into per-requester bytes.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      lane_addr[i] = req_addr[8*i +: 8];
      lane_data[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin pick: first requester at ptr+1, ptr+2, ... modulo N_REQ.
  always_comb begin
    logic [IW:0] cand;
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (IW+1)'(ptr_q) + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    err_d         = '0;
    ctrl_enable_d = ctrl_enable_q;
    ctrl_addr_d   = ctrl_addr_q;
    ctrl_data_d   = ctrl_data_q;
    ctrl_rsc_d    = ctrl_rsc_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    tcnt_d        = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);
    gap_d         = gap_q;

    case (state_q)
      IDLE: begin
        tcnt_d = tcnt_q;
        if (found) begin
          state_d       = LAUNCH;
          idx_d         = pick;
          gnt_d         = '0;
          gnt_d[pick]   = 1'b1;
          ctrl_enable_d = 1'b1;
          ctrl_addr_d   = lane_addr[pick];
          ctrl_data_d   = lane_data[pick];
          ctrl_rsc_d    = req_rsc[pick];
        end
      end
      LAUNCH: begin
        if (ctrl_busy) begin
          state_d       = WAIT_DONE;
          ctrl_enable_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d       = RELEASE;
          err_d         = gnt_q;
          ctrl_enable_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        // Completion wins over a timeout landing on the same edge.
        if (!ctrl_busy) begin
          state_d = RELEASE;
          done_d  = gnt_q;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = RELEASE;
          err_d   = gnt_q;
        end
      end
      RELEASE: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = idx_q;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Both counters restart on every state change.
    if (state_d != state_q) begin
      tcnt_d = '0;
      gap_d  = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i2c_core_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      done_q        <= '0;
      err_q         <= '0;
      busy_q        <= 1'b0;
      ctrl_enable_q <= 1'b0;
      ctrl_addr_q   <= '0;
      ctrl_data_q   <= '0;
      ctrl_rsc_q    <= 1'b0;
      ptr_q         <= IW'(N_REQ - 1);
      idx_q         <= '0;
      tcnt_q        <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      ctrl_enable_q <= ctrl_enable_d;
      ctrl_addr_q   <= ctrl_addr_d;
      ctrl_data_q   <= ctrl_data_d;
      ctrl_rsc_q    <= ctrl_rsc_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      tcnt_q        <= tcnt_d;
      gap_q         <= gap_d;
    end
  end

  assign gnt                 = gnt_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign busy                = busy_q;
  assign ctrl_enable         = ctrl_enable_q;
  assign ctrl_slave_address  = ctrl_addr_q;
  assign ctrl_data_in        = ctrl_data_q;
  assign ctrl_repeated_start = ctrl_rsc_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: a table of transactions plus a reset-abort sequence.
// A scoreboard queue holds the expected done/err pulse of every launched transaction.
module tb_i2c_txn_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned GAP     = 4;

  localparam int M_NORMAL = 0;  // controller goes busy then idle
  localparam int M_NEVER  = 1;  // controller never goes busy
  localparam int M_STUCK  = 2;  // controller goes busy and stays busy

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   req_addr;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_rsc;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     done;
  logic [N_REQ-1:0]     err;
  logic                 busy;
  logic                 ctrl_enable;
  logic [7:0]           ctrl_slave_address;
  logic [7:0]           ctrl_data_in;
  logic                 ctrl_repeated_start;
  logic                 ctrl_busy;

  i2c_txn_arbiter #(
    .N_REQ      (N_REQ),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP)
  ) dut (
    .i2c_core_clk        (clk),
    .rst                 (rst),
    .req                 (req),
    .req_addr            (req_addr),
    .req_data            (req_data),
    .req_rsc             (req_rsc),
    .gnt                 (gnt),
    .done                (done),
    .err                 (err),
    .busy                (busy),
    .ctrl_enable         (ctrl_enable),
    .ctrl_slave_address  (ctrl_slave_address),
    .ctrl_data_in        (ctrl_data_in),
    .ctrl_repeated_start (ctrl_repeated_start),
    .ctrl_busy           (ctrl_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [7:0] data;
    logic       rsc;
    int         dly;
    int         len;
    int         mode;
    logic       drop;
    logic [3:0] exp_gnt;
  } vec_t;

  typedef struct {
    logic [3:0] done;
    logic [3:0] err;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (done != '0 || err != '0)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%b err=%b, expected no pulse", done, err);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_done", 32'(done), 32'(mon_e.done));
        chk("sb_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_en"}, 32'(ctrl_enable), 32'h0);
    chk({tag, "_addr"}, 32'(ctrl_slave_address), 32'h0);
    chk({tag, "_data"}, 32'(ctrl_data_in), 32'h0);
    chk({tag, "_rsc"}, 32'(ctrl_repeated_start), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int         idx;
    int         p;
    int         hold;
    int         exp_lat;
    bit         hit;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       er;
    sb_t        e;
    string      t;
    t   = $sformatf("v%0d", n);
    idx = 0;
    for (int i = 0; i < int'(N_REQ); i++) if (v.exp_gnt[i]) idx = i;
    ea = v.addr + 8'(idx);
    ed = v.data ^ 8'(idx);
    er = v.rsc ^ 1'(idx & 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_addr[8*i +: 8] = v.addr + 8'(i);
      req_data[8*i +: 8] = v.data ^ 8'(i);
      req_rsc[i]         = v.rsc ^ 1'(i & 1);
    end
    req    = v.req;
    e.done = (v.mode == M_NORMAL) ? v.exp_gnt : 4'h0;
    e.err  = (v.mode == M_NORMAL) ? 4'h0 : v.exp_gnt;
    sb_q.push_back(e);

    // Grant appears one cycle after the request is seen.
    @(posedge clk);
    @(negedge clk);
    chk({t, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
    chk({t, "_en"}, 32'(ctrl_enable), 32'h1);
    chk({t, "_busy"}, 32'(busy), 32'h1);
    chk({t, "_addr"}, 32'(ctrl_slave_address), 32'(ea));
    chk({t, "_data"}, 32'(ctrl_data_in), 32'(ed));
    chk({t, "_rsc"}, 32'(ctrl_repeated_start), 32'(er));

    // Controller model; p counts rising edges since the grant edge.
    p   = 1;
    hit = 1'b0;
    if (v.mode != M_NEVER && v.dly == 0) ctrl_busy = 1'b1;
    while (!hit && p < int'(TIMEOUT) + 200) begin
      @(posedge clk);
      p++;
      #1;
      if (v.mode != M_NEVER && p == 1 + v.dly) ctrl_busy = 1'b1;
      if (v.mode == M_NORMAL && p == 1 + v.dly + v.len) ctrl_busy = 1'b0;
      if (v.drop && p == 3 + v.dly) begin
        req      = '0;
        req_addr = ~req_addr;
        req_data = ~req_data;
        req_rsc  = ~req_rsc;
      end
      @(negedge clk);
      if (done != '0 || err != '0) hit = 1'b1;
    end
    if (v.mode == M_NORMAL)     exp_lat = 1 + v.dly + v.len;
    else if (v.mode == M_NEVER) exp_lat = int'(TIMEOUT);
    else                        exp_lat = v.dly + 1 + int'(TIMEOUT);
    chk({t, "_latency"}, 32'(p - 1), 32'(exp_lat));
    chk({t, "_en_after"}, 32'(ctrl_enable), 32'h0);
    chk({t, "_addr_held"}, 32'(ctrl_slave_address), 32'(ea));
    chk({t, "_data_held"}, 32'(ctrl_data_in), 32'(ed));
    chk({t, "_rsc_held"}, 32'(ctrl_repeated_start), 32'(er));

    @(posedge clk);
    #1;
    ctrl_busy = 1'b0;
    req       = '0;

    // Grant stays up for the whole bus-free gap, starting with the pulse cycle.
    hold = 1;
    for (int k = 0; k < int'(GAP) + 20; k++) begin
      @(negedge clk);
      if (gnt == '0) break;
      hold++;
    end
    chk({t, "_gap"}, 32'(hold), 32'(GAP));
    chk({t, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v5;
    rst       = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_data  = '0;
    req_rsc   = '0;
    ctrl_busy = 1'b0;

    //           req      addr   data   rsc   dly len mode      drop  exp_gnt
    vecs[0]  = '{4'b0001, 8'hD7, 8'hAA, 1'b0, 2, 40, M_NORMAL, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1111, 8'h10, 8'h55, 1'b1, 1, 5,  M_NORMAL, 1'b0, 4'b0010};
    vecs[2]  = '{4'b1111, 8'h20, 8'h0F, 1'b0, 3, 8,  M_NORMAL, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1111, 8'h30, 8'hF0, 1'b1, 0, 2,  M_NORMAL, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1111, 8'h40, 8'h11, 1'b0, 2, 3,  M_NORMAL, 1'b0, 4'b0001};
    vecs[5]  = '{4'b0100, 8'h52, 8'h22, 1'b1, 0, 0,  M_NEVER,  1'b0, 4'b0100};
    vecs[6]  = '{4'b1001, 8'h64, 8'h33, 1'b0, 1, 0,  M_STUCK,  1'b0, 4'b1000};
    vecs[7]  = '{4'b0110, 8'hA5, 8'h44, 1'b1, 1, 10, M_NORMAL, 1'b1, 4'b0010};
    vecs[8]  = '{4'b0101, 8'hB6, 8'h66, 1'b0, 2, 4,  M_NORMAL, 1'b0, 4'b0100};
    vecs[9]  = '{4'b1011, 8'hC8, 8'h77, 1'b1, 1, 6,  M_NORMAL, 1'b0, 4'b1000};
    vecs[10] = '{4'b0011, 8'hE9, 8'h88, 1'b0, 0, 5,  M_NORMAL, 1'b0, 4'b0001};
    vecs[11] = '{4'b1110, 8'hF2, 8'h99, 1'b1, 1, 3,  M_NORMAL, 1'b0, 4'b0010};
    vecs[12] = '{4'b0010, 8'h5A, 8'hC3, 1'b0, 2, 7,  M_NORMAL, 1'b0, 4'b0010};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in the middle of a transaction: no pulse, everything back to zero.
    @(posedge clk);
    #1;
    req      = 4'b0100;
    req_addr = {8'h3C, 8'h3C, 8'h3C, 8'h3C};
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1;
    ctrl_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst_abort");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ctrl_busy = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_quiet_busy", 32'(busy), 32'h0);

    // Pointer restarts after reset; requester 1 gets the next grant.
    v5 = vecs[12];
    run_vec(v5, 12);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
